// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 keycode receiver: frame FSM
//               state encoding, PS/2 scan-code set 2 constants, USB HID
//               usage codes and the scan-code to HID translation function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan-code set 2 prefixes
  localparam logic [7:0] c_SC_EXT   = 8'hE0;
  localparam logic [7:0] c_SC_BRK   = 8'hF0;

  // Scan-code set 2 key codes (LEFT/RIGHT only valid after the E0 prefix)
  localparam logic [7:0] c_SC_A     = 8'h1C;
  localparam logic [7:0] c_SC_D     = 8'h23;
  localparam logic [7:0] c_SC_W     = 8'h1D;
  localparam logic [7:0] c_SC_S     = 8'h1B;
  localparam logic [7:0] c_SC_SPACE = 8'h29;
  localparam logic [7:0] c_SC_ENTER = 8'h5A;
  localparam logic [7:0] c_SC_LEFT  = 8'h6B;
  localparam logic [7:0] c_SC_RIGHT = 8'h74;

  // USB HID usage codes
  localparam logic [7:0] c_HID_NONE  = 8'h00;
  localparam logic [7:0] c_HID_A     = 8'h04;
  localparam logic [7:0] c_HID_D     = 8'h07;
  localparam logic [7:0] c_HID_W     = 8'h1A;
  localparam logic [7:0] c_HID_S     = 8'h16;
  localparam logic [7:0] c_HID_SPACE = 8'h2C;
  localparam logic [7:0] c_HID_ENTER = 8'h28;
  localparam logic [7:0] c_HID_LEFT  = 8'h50;
  localparam logic [7:0] c_HID_RIGHT = 8'h4F;

  // Translate a scan code (with its extended-prefix state) to a HID code.
  // Returns c_HID_NONE for anything not in the table, including a plain key
  // code that arrived with the E0 prefix or an arrow code without it.
  function automatic logic [7:0] f_sc_to_hid(input logic i_ext, input logic [7:0] i_sc);
    logic [7:0] w_hid;
    w_hid = c_HID_NONE;
    if (i_ext) begin
      case (i_sc)
        c_SC_LEFT:  w_hid = c_HID_LEFT;
        c_SC_RIGHT: w_hid = c_HID_RIGHT;
        default:    w_hid = c_HID_NONE;
      endcase
    end else begin
      case (i_sc)
        c_SC_A:     w_hid = c_HID_A;
        c_SC_D:     w_hid = c_HID_D;
        c_SC_W:     w_hid = c_HID_W;
        c_SC_S:     w_hid = c_HID_S;
        c_SC_SPACE: w_hid = c_HID_SPACE;
        c_SC_ENTER: w_hid = c_HID_ENTER;
        default:    w_hid = c_HID_NONE;
      endcase
    end
    return w_hid;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_filter
// Description : Brings the asynchronous PS/2 clock and data lines into the
//               system clock domain, de-glitches the PS/2 clock and produces
//               a one-cycle pulse on each falling edge of the cleaned clock.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               i_ps2_clk  - raw PS/2 clock line
//               i_ps2_dat  - raw PS/2 data line
//               o_dat      - synchronized PS/2 data
//               o_fall     - one-cycle pulse per filtered PS/2 clock fall
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_dat,
  output logic o_fall
);

  localparam int c_CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(FILTER_LEN - 1);

  logic [1:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic [c_CW-1:0] r_cnt;
  logic            r_clk_filt;
  logic            r_clk_filt_d;

  // Both lines idle high, so the synchronizers and the filtered clock reset
  // to 1; this keeps reset release from looking like a clock fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_cnt        <= '0;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], i_ps2_dat};
      r_clk_filt_d <= r_clk_filt;
      // r_cnt counts consecutive samples that disagree with the accepted
      // level; the new level is taken on the FILTER_LEN-th such sample.
      if (r_clk_sync[1] == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_clk_filt <= r_clk_sync[1];
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_dat  = r_dat_sync[1];
  assign o_fall = r_clk_filt_d & ~r_clk_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keycode_rx
// Description : PS/2 keyboard receiver. Deserializes 11-bit PS/2 frames,
//               checks odd parity and stop bit, tracks the E0/F0 prefixes
//               and reports the currently held mapped key as a USB HID code.
// Ports       : Clk       - system clock (rising edge)
//               Reset_n   - asynchronous active-low reset
//               PS2_CLK   - keyboard clock (asynchronous)
//               PS2_DAT   - keyboard data (asynchronous)
//               keycode   - HID code of the held mapped key, 0x00 = none
//               key_valid - one-cycle pulse per accepted make of a mapped key
//               frame_err - one-cycle pulse per discarded frame
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keycode_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  import ps2_pkg::*;

  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Line conditioning
  // --------------------------------------------------------------------------
  logic w_dat;
  logic w_fall;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_ps2_clk (PS2_CLK),
    .i_ps2_dat (PS2_DAT),
    .o_dat     (w_dat),
    .o_fall    (w_fall)
  );

  // --------------------------------------------------------------------------
  // State and next-state signals
  // --------------------------------------------------------------------------
  ps2_state_t      r_state,     w_state_n;
  logic [2:0]      r_bit_cnt,   w_bit_cnt_n;
  logic [7:0]      r_shift,     w_shift_n;
  logic            r_par,       w_par_n;
  logic            r_ext,       w_ext_n;
  logic            r_brk,       w_brk_n;
  logic [c_TW-1:0] r_to_cnt,    w_to_cnt_n;
  logic [7:0]      r_keycode,   w_keycode_n;
  logic            r_key_valid, w_key_valid_n;
  logic            r_frame_err, w_frame_err_n;

  logic [7:0]      w_hid;
  logic            w_frame_ok;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_to_cnt    <= '0;
      r_keycode   <= c_HID_NONE;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_shift     <= w_shift_n;
      r_par       <= w_par_n;
      r_ext       <= w_ext_n;
      r_brk       <= w_brk_n;
      r_to_cnt    <= w_to_cnt_n;
      r_keycode   <= w_keycode_n;
      r_key_valid <= w_key_valid_n;
      r_frame_err <= w_frame_err_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_shift_n     = r_shift;
    w_par_n       = r_par;
    w_ext_n       = r_ext;
    w_brk_n       = r_brk;
    w_to_cnt_n    = r_to_cnt;
    w_keycode_n   = r_keycode;
    w_key_valid_n = 1'b0;
    w_frame_err_n = 1'b0;

    w_hid      = f_sc_to_hid(r_ext, r_shift);
    // Odd parity: data plus parity bit has an odd number of ones.
    // Only meaningful in STOP, where w_dat is the stop bit.
    w_frame_ok = (^{r_shift, r_par}) & w_dat;

    if ((r_state != IDLE) && !w_fall) begin
      // Open frame waiting for its next bit: abort once the line has been
      // quiet for TIMEOUT cycles.
      if (r_to_cnt == c_TO_LAST) begin
        w_state_n     = IDLE;
        w_to_cnt_n    = '0;
        w_ext_n       = 1'b0;
        w_brk_n       = 1'b0;
        w_frame_err_n = 1'b1;
      end else begin
        w_to_cnt_n = r_to_cnt + 1'b1;
      end
    end else begin
      w_to_cnt_n = '0;
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            // A high start bit is noise or a misaligned frame: ignore it.
            if (!w_dat) begin
              w_state_n   = DATA;
              w_bit_cnt_n = 3'd0;
              w_shift_n   = 8'h00;
            end
          end
          DATA: begin
            // LSB arrives first, so shift in from the top.
            w_shift_n   = {w_dat, r_shift[7:1]};
            w_bit_cnt_n = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_n = PARITY;
            end
          end
          PARITY: begin
            w_par_n   = w_dat;
            w_state_n = STOP;
          end
          STOP: begin
            w_state_n = IDLE;
            if (!w_frame_ok) begin
              w_frame_err_n = 1'b1;
              w_ext_n       = 1'b0;
              w_brk_n       = 1'b0;
            end else if (r_shift == c_SC_EXT) begin
              w_ext_n = 1'b1;
            end else if (r_shift == c_SC_BRK) begin
              w_brk_n = 1'b1;
            end else begin
              // Any completed key byte ends the prefix sequence.
              w_ext_n = 1'b0;
              w_brk_n = 1'b0;
              if (w_hid != c_HID_NONE) begin
                if (r_brk) begin
                  // Releasing a key other than the held one is ignored.
                  if (w_hid == r_keycode) begin
                    w_keycode_n = c_HID_NONE;
                  end
                end else begin
                  w_keycode_n   = w_hid;
                  w_key_valid_n = 1'b1;
                end
              end
            end
          end
          default: begin
            w_state_n = IDLE;
          end
        endcase
      end
    end
  end

  assign keycode   = r_keycode;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keycode_rx
// Description : Self-checking bench for ps2_keycode_rx. Directed PS/2 frames
//               are driven bit by bit; a scan-code table model predicts the
//               held key and the pulse counts for every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_rx;

  import ps2_pkg::*;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 300;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .keycode   (keycode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int kv_seen = 0;
  int fe_seen = 0;
  int t_kv    = 0;
  bit in_frame = 1'b1;

  // Model state
  logic [7:0] exp_kc    = 8'h00;
  logic [7:0] exp_after = 8'h00;
  bit         m_ext     = 1'b0;
  bit         m_brk     = 1'b0;

  // Translation table: (extended, scan code) -> HID
  logic [7:0] map_sc  [8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h6B, 8'h74};
  bit         map_ext [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] map_hid [8] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C, 8'h28, 8'h50, 8'h4F};

  always @(posedge Clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    check("kv_fe_exclusive", {31'b0, key_valid & frame_err}, 32'd0);
    if (key_valid) begin
      kv_seen++;
      t_kv = cyc_n;
      check("keycode_at_key_valid", {24'b0, keycode}, {24'b0, exp_after});
    end
    if (frame_err) fe_seen++;
    if (!in_frame) check("keycode_stable", {24'b0, keycode}, {24'b0, exp_kc});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    PS2_DAT = v;
    cyc(10);
    PS2_CLK = 1'b0;
    cyc(20);
    PS2_CLK = 1'b1;
    cyc(10);
  endtask

  // Model of one byte: decides the expected keycode and pulses.
  task automatic model_byte(input logic [7:0] b, input bit ok, output bit kv, output bit fe);
    logic [7:0] hid;
    kv = 1'b0;
    fe = 1'b0;
    if (!ok) begin
      fe = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      hid = 8'h00;
      for (int i = 0; i < 8; i++)
        if (map_sc[i] == b && map_ext[i] == m_ext) hid = map_hid[i];
      if (hid != 8'h00) begin
        if (m_brk) begin
          if (hid == exp_kc) exp_after = 8'h00;
        end else begin
          exp_after = hid;
          kv = 1'b1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string name);
    int  kv0, fe0, t_stop, lat;
    bit  ekv, efe;
    logic p;
    in_frame  = 1'b1;
    exp_after = exp_kc;
    model_byte(b, !(bad_par || bad_stop), ekv, efe);
    kv0 = kv_seen;
    fe0 = fe_seen;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    PS2_DAT = ~bad_stop;
    cyc(10);
    PS2_CLK = 1'b0;
    t_stop = cyc_n;
    cyc(20);
    PS2_CLK = 1'b1;
    cyc(20);
    exp_kc   = exp_after;
    in_frame = 1'b0;
    check({name, "_key_valid_count"}, kv_seen - kv0, {31'b0, ekv});
    check({name, "_frame_err_count"}, fe_seen - fe0, {31'b0, efe});
    if (ekv) begin
      lat = t_kv - t_stop;
      check({name, "_latency_in_window"}, {31'b0, (lat >= 3 && lat <= FILTER_LEN + 6)}, 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, kv0;
    // Reset values
    cyc(3);
    check("reset_keycode", {24'b0, keycode}, 32'h00);
    check("reset_key_valid", {31'b0, key_valid}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    Reset_n = 1'b1;
    cyc(10);
    in_frame = 1'b0;

    // Make, typematic repeat, break of another key, own break
    send_frame(8'h1C, 0, 0, "make_A");
    check("lit_make_A", {24'b0, keycode}, 32'h04);
    send_frame(8'h1C, 0, 0, "typematic_A");
    check("lit_typematic_A", {24'b0, keycode}, 32'h04);
    send_frame(8'hF0, 0, 0, "brk_prefix1");
    send_frame(8'h23, 0, 0, "break_other");
    check("lit_break_other", {24'b0, keycode}, 32'h04);
    send_frame(8'hF0, 0, 0, "brk_prefix2");
    send_frame(8'h1C, 0, 0, "break_A");
    check("lit_break_A", {24'b0, keycode}, 32'h00);

    // Extended make and break
    send_frame(8'hE0, 0, 0, "ext_prefix1");
    send_frame(8'h74, 0, 0, "make_right");
    check("lit_make_right", {24'b0, keycode}, 32'h4F);
    send_frame(8'hE0, 0, 0, "ext_prefix2");
    send_frame(8'hF0, 0, 0, "brk_prefix3");
    send_frame(8'h74, 0, 0, "break_right");
    check("lit_break_right", {24'b0, keycode}, 32'h00);

    // Parity error
    send_frame(8'h23, 1, 0, "bad_parity");
    check("lit_bad_parity", {24'b0, keycode}, 32'h00);

    // Unmapped bytes leave the held key alone
    send_frame(8'h5A, 0, 0, "make_enter");
    send_frame(8'h15, 0, 0, "unmapped");
    send_frame(8'hE0, 0, 0, "ext_prefix3");
    send_frame(8'h1C, 0, 0, "ext_unmapped");
    check("lit_unmapped_hold", {24'b0, keycode}, 32'h28);
    send_frame(8'h1B, 0, 1, "bad_stop");
    check("lit_bad_stop", {24'b0, keycode}, 32'h28);
    send_frame(8'hF0, 0, 0, "brk_prefix4");
    send_frame(8'h5A, 0, 0, "break_enter");

    // Timeout mid-frame, after an E0 that must be forgotten
    send_frame(8'hE0, 0, 0, "ext_before_timeout");
    in_frame = 1'b1;
    fe0 = fe_seen;
    kv0 = kv_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    cyc(TIMEOUT + 20);
    m_ext = 1'b0;
    m_brk = 1'b0;
    in_frame = 1'b0;
    check("timeout_frame_err_count", fe_seen - fe0, 32'd1);
    check("timeout_key_valid_count", kv_seen - kv0, 32'd0);
    check("timeout_state_idle", {30'b0, dut.r_state}, {30'b0, IDLE});
    send_frame(8'h1D, 0, 0, "make_W_after_timeout");
    check("lit_make_W", {24'b0, keycode}, 32'h1A);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h23, 0, 0, "make_D");
    check("lit_make_D", {24'b0, keycode}, 32'h07);
    in_frame = 1'b1;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    PS2_DAT = 1'b1;
    cyc(10);
    PS2_CLK = 1'b0;
    cyc(5);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset_keycode", {24'b0, keycode}, 32'h00);
    check("async_reset_state_idle", {30'b0, dut.r_state}, {30'b0, IDLE});
    check("async_reset_key_valid", {31'b0, key_valid}, 32'd0);
    check("async_reset_frame_err", {31'b0, frame_err}, 32'd0);
    exp_kc = 8'h00;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    cyc(3);
    PS2_CLK = 1'b1;
    cyc(5);
    Reset_n = 1'b1;
    cyc(10);
    in_frame = 1'b0;
    send_frame(8'h29, 0, 0, "make_space_after_reset");
    check("lit_make_space", {24'b0, keycode}, 32'h2C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive identical Clk samples needed to accept a PS2_CLK level.
REQ-002 SHALL have parameter TIMEOUT, default 50000: Clk cycles without a PS2_CLK falling edge before an open frame is aborted.
REQ-003 SHALL have port Clk, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port PS2_CLK, input, 1: keyboard clock, asynchronous to Clk.
REQ-006 SHALL have port PS2_DAT, input, 1: keyboard data, asynchronous to Clk.
REQ-007 SHALL have port keycode, output, 8: HID code of the held mapped key; 0x00 = none.
REQ-008 SHALL have port key_valid, output, 1: one-cycle pulse on each accepted make of a mapped key.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on each discarded frame.

Function
REQ-010 SHALL pass PS2_CLK and PS2_DAT through 2-flop synchronizers, then filter PS2_CLK per FILTER_LEN; one falling edge of the filtered clock = one bit event.
REQ-011 SHALL sample PS2_DAT (synchronized) on each bit event; frame = start 0, 8 data LSB first, odd parity, stop 1.
REQ-012 SHALL use FSM states IDLE, DATA, PARITY, STOP: IDLE->DATA on start bit 0 (start bit 1 ignored, stay IDLE); DATA->PARITY after 8th bit; PARITY->STOP after parity bit; STOP->IDLE after stop bit.
REQ-013 SHALL, on parity mismatch or stop bit 0, discard the byte, pulse frame_err, clear the E0/F0 flags, return to IDLE.
REQ-014 SHALL, in any non-IDLE state with no bit event for TIMEOUT cycles, pulse frame_err, clear flags, return to IDLE.
REQ-015 SHALL treat byte 0xE0 as setting the extended flag and 0xF0 as setting the break flag; neither changes keycode.
REQ-016 SHALL translate (flag state, byte): 1C->04, 23->07, 1D->1A, 1B->16, 29->2C, 5A->28, E0+6B->50, E0+74->4F; any other byte is unmapped and ignored.
REQ-017 SHALL, on a mapped make, set keycode to the HID code and pulse key_valid in the cycle after the stop-bit event (latency 1 cycle).
REQ-018 SHALL, on a repeated make of the key already in keycode (typematic), leave keycode unchanged and pulse key_valid again.
REQ-019 SHALL, on a mapped break matching the current keycode, set keycode to 0x00 with no key_valid; a break of any other key SHALL leave keycode unchanged.
REQ-020 SHALL clear both flags after any completed non-prefix byte, mapped or not.
REQ-021 SHALL hold keycode stable between decoded bytes; key_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-022 SHALL, while Reset_n is low, force FSM to IDLE, bit counter, shift register, flags and timeout counter to 0, and keycode, key_valid, frame_err to 0, irrespective of Clk.
REQ-023 SHALL discard any frame in progress when Reset_n asserts; the first frame accepted after release SHALL begin with a fresh start bit.

Structure
REQ-024 SHALL place the FSM state enum, scan-code constants (E0, F0, set-2 codes) and HID constants in shared package ps2_pkg.
REQ-025 SHALL implement synchronizers, FILTER_LEN filter and falling-edge detect in sub-module ps2_filter (outputs: filtered data, fall pulse).

Verification
REQ-026 SHALL cover: frame 0x1C, parity 0, stop 1 -> keycode 0x04 one Clk after stop edge, single key_valid pulse.
REQ-027 SHALL cover: then F0,1C -> keycode 0x00, no key_valid, no frame_err.
REQ-028 SHALL cover: E0,74 -> keycode 0x4F, one key_valid pulse; then E0,F0,74 -> keycode 0x00.
REQ-029 SHALL cover: 0x23 sent with parity 1 -> one frame_err pulse, keycode unchanged, no key_valid.
REQ-030 SHALL cover: 6 bits then idle TIMEOUT+1 cycles -> one frame_err pulse, FSM IDLE; next good 0x1D -> keycode 0x1A.
REQ-031 SHALL cover: keycode 0x07 held, Reset_n low mid-frame -> keycode 0x00 and FSM IDLE same cycle; after release a good 0x29 -> keycode 0x2C.
